// File: rtl/pwm_pkg.sv
// pwm_pkg: write-select codes and reset values shared by the PWM channel files.
package pwm_pkg;

  // Write target encoding for wr_sel.
  localparam logic [1:0] SEL_PRESC  = 2'd0;
  localparam logic [1:0] SEL_PERIOD = 2'd1;
  localparam logic [1:0] SEL_DUTY   = 2'd2;
  localparam logic [1:0] SEL_DT     = 2'd3;

  // Reset values, sliced down to each register's width where they are used.
  localparam logic [31:0] RST_PRESC  = 32'h0000_0000;
  localparam logic [31:0] RST_PERIOD = 32'hFFFF_FFFF;
  localparam logic [31:0] RST_DUTY   = 32'h0000_0000;
  localparam logic [31:0] RST_DT     = 32'h0000_0000;
  localparam logic [31:0] RST_CNT    = 32'h0000_0000;
  localparam logic        RST_OUT    = 1'b0;

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clk by (presc + 1); tick marks the last cycle of each division.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [PRESC_WIDTH-1:0] presc,
  output logic                   tick
);

  logic [PRESC_WIDTH-1:0] pcnt_q;

  assign tick = en && (pcnt_q == presc);

  // Count 0..presc while enabled, held at zero when idle.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      pcnt_q <= RST_CNT[PRESC_WIDTH-1:0];
    end else if (tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM channel with prescaler, period counter, duty compare and
// double-buffered configuration. Optional dead-time / complementary output is
// enabled with the PWM_DEADTIME_EN macro.
// PRESC_WIDTH and DT_WIDTH must not exceed WIDTH (wr_data is truncated into them).
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PRESC_WIDTH = 8,
  parameter int unsigned DT_WIDTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  output logic             pwm,
`ifdef PWM_DEADTIME_EN
  output logic             pwm_n,
`endif
  output logic             period_end,
  output logic             upd_pend
);

  logic [PRESC_WIDTH-1:0] presc_sh_q, presc_act_q;
  logic [WIDTH-1:0]       period_sh_q, period_act_q;
  logic [WIDTH-1:0]       duty_sh_q, duty_act_q;
  logic [WIDTH-1:0]       cnt_q;
  logic                   tick, wrap, load, wr_ok, raw;
  logic                   pwm_q, pe_q, pend_q;

`ifdef PWM_DEADTIME_EN
  assign wr_ok = wr_en;
`else
  assign wr_ok = wr_en && (wr_sel != SEL_DT);
`endif

  pwm_prescaler #(
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .presc (presc_act_q),
    .tick  (tick)
  );

  // tick already implies en; an idle channel reloads its active copy every cycle.
  assign wrap = tick && (cnt_q == period_act_q);
  assign load = !en || wrap;
  assign raw  = (cnt_q < duty_act_q);

  // Shadow registers take writes; the active copy below still sees the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_sh_q  <= RST_PRESC[PRESC_WIDTH-1:0];
      period_sh_q <= RST_PERIOD[WIDTH-1:0];
      duty_sh_q   <= RST_DUTY[WIDTH-1:0];
    end else if (wr_ok) begin
      case (wr_sel)
        SEL_PRESC:  presc_sh_q  <= wr_data[PRESC_WIDTH-1:0];
        SEL_PERIOD: period_sh_q <= wr_data;
        SEL_DUTY:   duty_sh_q   <= wr_data;
        default:    ;
      endcase
    end
  end

  // Active registers follow the shadow at each period boundary or while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_act_q  <= RST_PRESC[PRESC_WIDTH-1:0];
      period_act_q <= RST_PERIOD[WIDTH-1:0];
      duty_act_q   <= RST_DUTY[WIDTH-1:0];
    end else if (load) begin
      presc_act_q  <= presc_sh_q;
      period_act_q <= period_sh_q;
      duty_act_q   <= duty_sh_q;
    end
  end

  // Pending flag: a write wins over a simultaneous load so the new value is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= RST_OUT;
    end else if (wr_ok) begin
      pend_q <= 1'b1;
    end else if (load) begin
      pend_q <= 1'b0;
    end
  end

  // Period counter advances on prescaler ticks and wraps after period_act.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= RST_CNT[WIDTH-1:0];
    end else if (tick) begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // Registered period-end strobe, one cycle after the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pe_q <= RST_OUT;
    end else begin
      pe_q <= wrap;
    end
  end

`ifdef PWM_DEADTIME_EN
  logic [DT_WIDTH-1:0] dt_sh_q, dt_act_q, dcnt_q, dcnt_d;
  logic                phase_q, pwm_n_q;

  // Dead-time shadow/active pair, loaded together with the other registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dt_sh_q  <= RST_DT[DT_WIDTH-1:0];
      dt_act_q <= RST_DT[DT_WIDTH-1:0];
    end else begin
      if (wr_ok && (wr_sel == SEL_DT)) begin
        dt_sh_q <= wr_data[DT_WIDTH-1:0];
      end
      if (load) begin
        dt_act_q <= dt_sh_q;
      end
    end
  end

  // Restart the gap counter on every raw edge, otherwise run it down to zero.
  always_comb begin
    dcnt_d = '0;
    if (!en) begin
      dcnt_d = '0;
    end else if (raw != phase_q) begin
      dcnt_d = dt_act_q;
    end else if (dcnt_q != '0) begin
      dcnt_d = dcnt_q - 1'b1;
    end
  end

  // Both outputs held low while a gap is running; idle phase counts as low.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      dcnt_q  <= '0;
      pwm_q   <= RST_OUT;
      pwm_n_q <= RST_OUT;
    end else begin
      phase_q <= en && raw;
      dcnt_q  <= dcnt_d;
      pwm_q   <= en && raw && (dcnt_d == '0);
      pwm_n_q <= en && !raw && (dcnt_d == '0);
    end
  end

  assign pwm_n = pwm_n_q;
`else
  // Plain registered compare output.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= RST_OUT;
    end else begin
      pwm_q <= en && raw;
    end
  end
`endif

  assign pwm        = pwm_q;
  assign period_end = pe_q;
  assign upd_pend   = pend_q;

endmodule

// File: doc/pwm_channel.md
# pwm_channel

Single PWM channel: a programmable prescaler, a period counter and a duty comparator, with double-buffered configuration registers. It sits directly upstream of the toggle flip-flop stage. Its one-cycle `period_end` strobe drives that stage's `t` input to produce a 50 % sync square wave at half the PWM frequency. Its `pwm` output is the main generated signal.

## Interface
- `WIDTH`, 8: width of the period and duty registers and of the period counter.
- `PRESC_WIDTH`, 8: width of the prescaler register and counter.
- `DT_WIDTH`, 4: width of the dead-time register. Used only when `PWM_DEADTIME_EN` is defined.
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable.
- `wr_en`  in  1  one-cycle write strobe.
- `wr_sel`  in  2  write target: 0 prescaler, 1 period, 2 duty, 3 dead time.
- `wr_data`  in  `WIDTH`  write data. Truncated to the target register's width.
- `pwm`  out  1  PWM output, registered.
- `pwm_n`  out  1  complementary output. Present only when `PWM_DEADTIME_EN` is defined.
- `period_end`  out  1  one-cycle pulse on the last tick of each period, registered.
- `upd_pend`  out  1  a shadow value is waiting to be loaded into the active registers.

## Operation
- Every register has a shadow copy and an active copy. Writes go to the shadow only, and each write sets `upd_pend`.
- Reset values:
  - Shadow and active registers: prescaler 0, period all-ones, duty 0, dead time 0.
  - Counters: 0.
  - Outputs: `pwm`, `pwm_n`, `period_end` and `upd_pend` all 0.
- Prescaler:
  - `pcnt` counts 0..`presc_act`.
  - `tick` is asserted when `pcnt == presc_act`, and `pcnt` then wraps to 0.
  - With `presc_act = 0`, `tick` is asserted every cycle.
- Period counter:
  - Advances only on `tick`.
  - At `cnt == period_act` with `tick`, it wraps to 0. On that same cycle the period-end event occurs: the shadow is copied into the active registers and `upd_pend` is cleared.
- Raw compare: `raw = (cnt < duty_act)`, as an unsigned compare.
  - `duty_act = 0` gives a constant-low output.
  - `duty_act > period_act` gives a constant-high output (100 %).
- `en = 0` (idle):
  - Both counters are held at 0.
  - `pwm`, `pwm_n` and `period_end` are 0.
  - The active registers load the shadow on every cycle, and `upd_pend` is cleared.
- Write and load in the same cycle: the active copy takes the pre-write shadow value. The new value applies at the following boundary, and `upd_pend` stays 1.
- `rst` in the middle of a period: everything is forced to its reset value on the next edge, and no `period_end` is emitted.

## Timing
- Output period: `(presc_act+1)*(period_act+1)` clk cycles.
- Output high time: `(presc_act+1)*min(duty_act, period_act+1)` cycles.
- `pwm` is the registered form of `raw`: it lags the counter state by 1 cycle.
- `period_end` is registered and is high for exactly 1 cycle per period, in the cycle after the wrap event.
- Start-up after `en` rises: counting starts from 0 on the same edge. The first `pwm` high appears 1 cycle later, provided `duty_act > 0`.
- Write latency: `wr_data` is visible in the shadow, and `upd_pend` is set, 1 cycle after `wr_en`.

## Configuration
- Macro: `PWM_DEADTIME_EN`.
- When defined:
  - `pwm_n` is added. It is the complement of the `pwm` phase.
  - On every edge of `raw`, both outputs are driven low for `dt_act` cycles; the newly active output then goes high.
  - If the pulse is shorter than the dead time, that output stays low for the whole pulse.
  - `dt_act = 0` gives a pure complement with no gap.
  - The two outputs are never high together.
- When not defined:
  - `pwm_n` and the dead-time logic are absent.
  - Writes with `wr_sel = 3` are ignored and do not set `upd_pend`.

## Structure
- Package `pwm_pkg` holds:
  - Constants `SEL_PRESC`, `SEL_PERIOD`, `SEL_DUTY`, `SEL_DT`.
  - The reset-value constants.
- Sub-module `pwm_prescaler` contains the `pcnt` counter and produces `tick`. It has ports `clk`, `rst`, `en`, `presc` and `tick`.
- All other logic is in `pwm_channel`.

## Test plan
- Duty cycle: after reset, write prescaler=0, period=9, duty=3, then set `en=1`. Expect `pwm` high 3 / low 7 cycles repeating, and `period_end` every 10 cycles.
- Prescaler: prescaler=1, period=3, duty=2. Expect a period of 8 cycles, high for 4, and `period_end` spaced 8 apart.
- Double buffering: during a period, write duty=8 with period=9. The current period keeps duty 3, the next period is high for 8, and `upd_pend` falls on the load.
- Extreme duties: duty=0 gives a constant-low `pwm`. Duty=200 with period=9 gives a constant-high `pwm`. `period_end` keeps pulsing in both cases.
- Reset mid-run: assert `rst` at cycle 5 of a period. On the next edge expect `pwm=0`, `period_end=0`, `upd_pend=0`, and period back at 255.
- Dead time (only with `PWM_DEADTIME_EN`): dt=2, period=9, duty=5. Expect 2-cycle both-low gaps at each transition, `pwm` high for 3, `pwm_n` high for 3, and never both high at once.
